// File: rtl/mem_arb_2to1.sv
// mem_arb_2to1: merges two val/rdy memory request streams onto one memory
// port and steers the in-order responses back to the issuing client. A small
// FIFO of 1-bit grant IDs remembers which client owns each outstanding
// request. Request and response messages are passed through untouched.
//
// Handshake: every *_val/*_rdy pair transfers one message on a rising clk
// edge where both val and rdy are high. A val never depends on its own rdy.
// Senders hold val and msg stable until the transfer happens. Request rdy
// depends only on arbitration state and memreq_rdy, not on any memresp_*
// signal, so there is no combinational path from response to request side.
module mem_arb_2to1 #(
   parameter int p_addr_sz      = 8,
   parameter int p_data_sz      = 32,
   parameter int p_max_inflight = 4,
   localparam int c_len_sz      = $clog2(p_data_sz/8),
   localparam int c_req_msg_sz  = 1 + p_addr_sz + c_len_sz + p_data_sz,
   localparam int c_resp_msg_sz = 1 + c_len_sz + p_data_sz
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic                     req0_val,
   output logic                     req0_rdy,
   input  logic [c_req_msg_sz-1:0]  req0_msg,
   output logic                     resp0_val,
   input  logic                     resp0_rdy,
   output logic [c_resp_msg_sz-1:0] resp0_msg,

   input  logic                     req1_val,
   output logic                     req1_rdy,
   input  logic [c_req_msg_sz-1:0]  req1_msg,
   output logic                     resp1_val,
   input  logic                     resp1_rdy,
   output logic [c_resp_msg_sz-1:0] resp1_msg,

   output logic                     memreq_val,
   input  logic                     memreq_rdy,
   output logic [c_req_msg_sz-1:0]  memreq_msg,
   input  logic                     memresp_val,
   output logic                     memresp_rdy,
   input  logic [c_resp_msg_sz-1:0] memresp_msg
);

   localparam int c_ptr_sz = $clog2(p_max_inflight);
   localparam int c_cnt_sz = c_ptr_sz + 1;

   // Round-robin priority and the order FIFO (one grant ID per entry).
   logic                      prio;
   logic [p_max_inflight-1:0] order;
   logic [c_ptr_sz-1:0]       head_ptr;
   logic [c_ptr_sz-1:0]       tail_ptr;
   logic [c_cnt_sz-1:0]       count;

   logic full;
   logic empty;
   logic grant;
   logic head;
   logic push;
   logic pop;

   assign full  = (count == c_cnt_sz'(p_max_inflight));
   assign empty = (count == '0);
   assign head  = order[head_ptr];

   // Request side: pick a client, forward its message, steer the ready.
   always_comb begin
      grant      = 1'b0;
      memreq_val = 1'b0;
      memreq_msg = req0_msg;
      req0_rdy   = 1'b0;
      req1_rdy   = 1'b0;
      if (req0_val && req1_val) begin
         grant = prio;
      end else if (req1_val) begin
         grant = 1'b1;
      end
      memreq_val = (req0_val | req1_val) & ~full & ~reset;
      memreq_msg = grant ? req1_msg : req0_msg;
      req0_rdy   = ~grant & memreq_rdy & ~full & ~reset;
      req1_rdy   =  grant & memreq_rdy & ~full & ~reset;
   end

   // Response side: the FIFO head names the owner of the current response;
   // only the val lines are steered, the message fans out to both clients.
   always_comb begin
      resp0_val   = memresp_val & ~empty & ~head & ~reset;
      resp1_val   = memresp_val & ~empty &  head & ~reset;
      resp0_msg   = memresp_msg;
      resp1_msg   = memresp_msg;
      memresp_rdy = ~empty & (head ? resp1_rdy : resp0_rdy) & ~reset;
   end

   assign push = memreq_val & memreq_rdy;
   assign pop  = memresp_val & memresp_rdy;

   // Order FIFO and priority update; the served client loses priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio     <= 1'b0;
         order    <= '0;
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            order[tail_ptr] <= grant;
            tail_ptr        <= tail_ptr + c_ptr_sz'(1);
            prio            <= ~grant;
         end
         if (pop) begin
            head_ptr <= head_ptr + c_ptr_sz'(1);
         end
         if (push && !pop) begin
            count <= count + c_cnt_sz'(1);
         end else if (pop && !push) begin
            count <= count - c_cnt_sz'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_arb_2to1.sv
// Testbench for mem_arb_2to1: an in-order behavioural memory sits on the
// memory side; client drivers push expected responses into per-client queues
// as their requests are accepted, and a monitor pops and compares them.
module tb_mem_arb_2to1;

   localparam int RQ = 43;
   localparam int RS = 35;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0_val = 1'b0, req1_val = 1'b0;
   logic          req0_rdy, req1_rdy;
   logic [RQ-1:0] req0_msg = '0, req1_msg = '0;
   logic          resp0_val, resp1_val;
   logic          resp0_rdy = 1'b1, resp1_rdy = 1'b1;
   logic [RS-1:0] resp0_msg, resp1_msg;
   logic          memreq_val, memresp_rdy;
   logic          memreq_rdy = 1'b1;
   logic [RQ-1:0] memreq_msg;
   logic          memresp_val = 1'b0;
   logic [RS-1:0] memresp_msg = '0;

   int checks = 0;
   int errors = 0;

   logic [RS-1:0] exp0_q[$];
   logic [RS-1:0] exp1_q[$];
   logic          grant_log[$];
   logic          resp_log[$];

   logic [RS-1:0] pend_q[$];
   logic [31:0]   mem [0:63];
   logic          mm_rst, mm_rq_fire, mm_rs_fire;
   logic [RQ-1:0] mm_rq_msg;
   logic [RS-1:0] mon_exp;

   mem_arb_2to1 dut (
      .clk(clk), .reset(reset),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
      .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
      .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   function automatic logic [RQ-1:0] rd(input logic [7:0] addr);
      return {1'b0, addr, 2'b00, 32'h0};
   endfunction

   function automatic logic [RQ-1:0] wr(input logic [7:0] addr, input logic [31:0] data);
      return {1'b1, addr, 2'b00, data};
   endfunction

   function automatic logic [RS-1:0] rd_resp(input logic [31:0] data);
      return {1'b0, 2'b00, data};
   endfunction

   // In-order memory, one cycle minimum latency, responses queue while stalled
   always begin
      @(negedge clk);
      mm_rst     = reset;
      mm_rq_fire = memreq_val && memreq_rdy;
      mm_rs_fire = memresp_val && memresp_rdy;
      mm_rq_msg  = memreq_msg;
      @(posedge clk);
      #1;
      if (mm_rst) begin
         pend_q.delete();
      end else begin
         if (mm_rs_fire && pend_q.size() > 0) void'(pend_q.pop_front());
         if (mm_rq_fire) begin
            if (mm_rq_msg[42]) begin
               mem[mm_rq_msg[41:36]] = mm_rq_msg[31:0];
               pend_q.push_back({1'b1, 2'b00, 32'h0});
            end else begin
               pend_q.push_back({1'b0, 2'b00, mem[mm_rq_msg[41:36]]});
            end
         end
      end
      memresp_val = (pend_q.size() > 0);
      memresp_msg = (pend_q.size() > 0) ? pend_q[0] : '0;
   end

   // Scoreboard monitor: compare delivered responses, log grants and order
   always @(negedge clk) begin
      if (!reset) begin
         if (resp0_val && resp0_rdy) begin
            resp_log.push_back(1'b0);
            checks++;
            if (exp0_q.size() == 0) begin
               errors++;
               $display("FAIL resp0_unexpected: got %h, required no response", resp0_msg);
            end else begin
               mon_exp = exp0_q.pop_front();
               if (resp0_msg !== mon_exp) begin
                  errors++;
                  $display("FAIL resp0_data: got %h, required %h", resp0_msg, mon_exp);
               end
            end
         end
         if (resp1_val && resp1_rdy) begin
            resp_log.push_back(1'b1);
            checks++;
            if (exp1_q.size() == 0) begin
               errors++;
               $display("FAIL resp1_unexpected: got %h, required no response", resp1_msg);
            end else begin
               mon_exp = exp1_q.pop_front();
               if (resp1_msg !== mon_exp) begin
                  errors++;
                  $display("FAIL resp1_data: got %h, required %h", resp1_msg, mon_exp);
               end
            end
         end
         if (memresp_val) begin
            checks++;
            if ((resp0_val ^ resp1_val) !== 1'b1) begin
               errors++;
               $display("FAIL resp_steer: got resp0_val=%b resp1_val=%b, required exactly one",
                        resp0_val, resp1_val);
            end
         end
         if (req0_val && req0_rdy) grant_log.push_back(1'b0);
         if (req1_val && req1_rdy) grant_log.push_back(1'b1);
      end
   end

   // Driver: present one request on a port until accepted
   task automatic send(input int port, input logic [RQ-1:0] msg, input logic [RS-1:0] exp);
      bit done = 0;
      if (port == 0) begin req0_val = 1'b1; req0_msg = msg; end
      else begin req1_val = 1'b1; req1_msg = msg; end
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if ((port == 0) ? req0_rdy : req1_rdy) begin
            done = 1;
            if (port == 0) exp0_q.push_back(exp);
            else exp1_q.push_back(exp);
         end
      end
      @(posedge clk);
      #1;
      if (port == 0) req0_val = 1'b0;
      else req1_val = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: port %0d got no rdy, required rdy within 100 cycles", port);
      end
   endtask

   task automatic wait_drain();
      int i = 0;
      while ((exp0_q.size() > 0 || exp1_q.size() > 0) && i < 200) begin
         @(posedge clk);
         i++;
      end
      #1;
      if (exp0_q.size() > 0 || exp1_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0",
                  exp0_q.size(), exp1_q.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp0_q.delete();
      exp1_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      req0_val = 1'b1;
      req1_val = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({memreq_val, req0_rdy, req1_rdy, memresp_rdy, resp0_val, resp1_val} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 000000",
                  {memreq_val, req0_rdy, req1_rdy, memresp_rdy, resp0_val, resp1_val});
      end
      @(posedge clk);
      #1;
      req0_val = 1'b0;
      req1_val = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      checks++;
      if ({memreq_val, memresp_rdy, req0_rdy, req1_rdy} !== 4'b0010) begin
         errors++;
         $display("FAIL idle_after_reset: got %b, required 0010",
                  {memreq_val, memresp_rdy, req0_rdy, req1_rdy});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      send(0, wr(8'h10, 32'hdeadbeef), {1'b1, 2'b00, 32'h0});
      send(0, rd(8'h10), rd_resp(32'hdeadbeef));
      wait_drain();
   endtask

   task automatic test_contention();
      logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      grant_log.delete();
      fork
         begin
            send(0, rd(8'h00), rd_resp(32'h11111111));
            send(0, rd(8'h00), rd_resp(32'h11111111));
         end
         begin
            send(1, rd(8'h04), rd_resp(32'h22222222));
            send(1, rd(8'h04), rd_resp(32'h22222222));
         end
      join
      wait_drain();
      checks++;
      if (grant_log.size() != 4) begin
         errors++;
         $display("FAIL contention_count: got %0d grants, required 4", grant_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_log[i] !== exp_g[i]) begin
               errors++;
               $display("FAIL contention_grant%0d: got %b, required %b", i, grant_log[i], exp_g[i]);
            end
         end
      end
   endtask

   task automatic test_fill();
      grant_log.delete();
      resp0_rdy = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               if (i % 2 == 0) send(0, rd(8'h00), rd_resp(32'h11111111));
               else send(0, rd(8'h10), rd_resp(32'hdeadbeef));
            end
         end
         begin
            int n = 0;
            while (grant_log.size() < 4 && n < 100) begin
               @(posedge clk);
               n++;
            end
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               checks++;
               if ({memreq_val, req0_rdy} !== 2'b00) begin
                  errors++;
                  $display("FAIL fill_blocked%0d: got memreq_val/req0_rdy=%b, required 00",
                           k, {memreq_val, req0_rdy});
               end
            end
            @(posedge clk);
            checks++;
            if (grant_log.size() != 4) begin
               errors++;
               $display("FAIL fill_accepted: got %0d, required 4", grant_log.size());
            end
            #1;
            resp0_rdy = 1'b1;
            @(negedge clk);
            checks++;
            if ({req0_rdy, memresp_rdy} !== 2'b01) begin
               errors++;
               $display("FAIL fill_pop_cycle: got req0_rdy/memresp_rdy=%b, required 01",
                        {req0_rdy, memresp_rdy});
            end
            @(negedge clk);
            checks++;
            if (req0_rdy !== 1'b1) begin
               errors++;
               $display("FAIL fill_after_pop: got req0_rdy=%b, required 1", req0_rdy);
            end
         end
      join
      wait_drain();
   endtask

   task automatic test_interleave();
      logic exp_o [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      resp_log.delete();
      resp1_rdy = 1'b0;
      fork
         begin
            send(1, rd(8'h04), rd_resp(32'h22222222));
            send(0, rd(8'h00), rd_resp(32'h11111111));
            send(0, rd(8'h10), rd_resp(32'hdeadbeef));
            send(1, rd(8'h04), rd_resp(32'h22222222));
         end
         begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
               @(negedge clk);
               seen = resp1_val;
            end
            if (!seen) begin
               checks++;
               errors++;
               $display("FAIL stall_wait: got no resp1_val, required resp1_val within 50 cycles");
            end
            for (int k = 0; k < 3; k++) begin
               if (k > 0) @(negedge clk);
               checks++;
               if (memresp_rdy !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_memresp_rdy%0d: got %b, required 0", k, memresp_rdy);
               end
            end
            @(posedge clk);
            #1;
            resp1_rdy = 1'b1;
         end
      join
      wait_drain();
      checks++;
      if (resp_log.size() != 4) begin
         errors++;
         $display("FAIL interleave_count: got %0d responses, required 4", resp_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_log[i] !== exp_o[i]) begin
               errors++;
               $display("FAIL interleave_order%0d: got client %b, required %b", i, resp_log[i], exp_o[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      resp0_rdy = 1'b0;
      send(0, rd(8'h00), rd_resp(32'h11111111));
      send(0, rd(8'h00), rd_resp(32'h11111111));
      send(0, rd(8'h10), rd_resp(32'hdeadbeef));
      reset = 1'b1;
      exp0_q.delete();
      exp1_q.delete();
      @(negedge clk);
      checks++;
      if ({memreq_val, req0_rdy, req1_rdy, memresp_rdy, resp0_val, resp1_val} !== 6'b0) begin
         errors++;
         $display("FAIL midreset_outputs: got %b, required 000000",
                  {memreq_val, req0_rdy, req1_rdy, memresp_rdy, resp0_val, resp1_val});
      end
      @(posedge clk);
      #1;
      reset     = 1'b0;
      resp0_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if ({memresp_rdy, resp0_val, resp1_val, memreq_val, req0_rdy, req1_rdy} !== 6'b000010) begin
         errors++;
         $display("FAIL midreset_cleared: got %b, required 000010",
                  {memresp_rdy, resp0_val, resp1_val, memreq_val, req0_rdy, req1_rdy});
      end
      @(posedge clk);
      #1;
      grant_log.delete();
      fork
         send(0, rd(8'h00), rd_resp(32'h11111111));
         send(1, rd(8'h04), rd_resp(32'h22222222));
      join
      wait_drain();
      checks++;
      if (grant_log.size() != 2 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_prio: got %0d grants first=%b, required 2 grants 0 then 1",
                  grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 1'bx);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'h11111111;
      mem[1] = 32'h22222222;
      test_reset();
      test_single();
      test_contention();
      test_fill();
      test_interleave();
      test_reset_mid();
      repeat (3) @(posedge clk);
      checks++;
      if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
         errors++;
         $display("FAIL final_drain: got %0d/%0d outstanding, required 0/0", exp0_q.size(), exp1_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
